// File: rtl/fifo_reader.sv
// Read-side engine of the pointer FIFO: owns r_ptr, drives a synchronous-read
// storage port and prefetches into a 2-entry output buffer on a valid/ready stream.
module fifo_reader #(
  parameter int unsigned SIZE  = 5,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = $clog2(SIZE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    i_w_ptr,
  input  logic             i_flush,
  output logic             o_rd_en,
  output logic [PW-1:0]    o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic [PW-1:0]    o_r_ptr,
  output logic [PW-1:0]    o_level,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic [PW-1:0]    r_ptr;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  logic             w_empty;
  logic             w_pop;
  logic             w_issue;
  logic [2:0]       w_sum;
  logic [1:0]       w_occ_after_pop;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_level;

  // w_sum is the buffer occupancy after this edge; pop implies occ >= 1, so no underflow
  assign w_empty         = (i_w_ptr == r_ptr);
  assign w_pop           = r_out_valid & i_out_ready;
  assign w_sum           = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue         = rst_n & ~w_empty & ~i_flush & (w_sum < 3'd2);
  assign w_occ_after_pop = r_occ - 2'(w_pop);
  assign w_ptr_inc       = (r_ptr == PW'(SIZE - 1)) ? '0 : r_ptr + PW'(1);

  always_comb begin
    w_level = '0;
    if (i_w_ptr >= r_ptr) w_level = i_w_ptr - r_ptr;
    else                  w_level = i_w_ptr + PW'(SIZE) - r_ptr;
  end

  assign o_rd_en     = w_issue;
  assign o_rd_addr   = r_ptr;
  assign o_r_ptr     = r_ptr;
  assign o_level     = w_level;
  assign o_out_data  = r_head;
  assign o_out_valid = r_out_valid;

  // Pointer and occupancy bookkeeping; flush wins over pop and issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_ptr       <= i_w_ptr;
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_issue) r_ptr <= w_ptr_inc;
      r_occ       <= w_sum[1:0];
      r_inflight  <= w_issue;
      r_out_valid <= (w_sum != 3'd0);
    end
  end

  // Head/tail buffer: returning data lands in head if the buffer is empty after the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_flush) begin
      if (w_pop && (r_occ == 2'd2)) r_head <= r_tail;
      if (r_inflight) begin
        if (w_occ_after_pop == 2'd0) r_head <= i_rd_data;
        else                         r_tail <= i_rd_data;
      end
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) (i_flush || (w_sum <= 3'd2)));

endmodule
